// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-issue PC owner: fetch, issue to decoder, resolve redirects.
// Optional PERF_CNT_EN adds retired_cnt / taken_cnt outputs.
module fetch_sequencer #(
   parameter int              PC_W     = 32,
   parameter int              INSTR_W  = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    pc_plus1,
   input  logic               resolve_valid,
   input  logic               branchN,
   input  logic               branchZ,
   input  logic               Jump,
   input  logic               jumpMem,
   input  logic [PC_W-1:0]    reg_target,
   input  logic [PC_W-1:0]    mem_target,
   input  logic               flag_we,
   input  logic               alu_z,
   input  logic               alu_n,
`ifdef PERF_CNT_EN
   output logic [31:0]        retired_cnt,
   output logic [31:0]        taken_cnt,
`endif
   output logic               busy
);

   typedef enum logic [1:0] {FETCH, WAIT, ISSUE, RESOLVE} state_t;

   state_t          state;
   logic [PC_W-1:0] pc;
   logic            z_flag;
   logic            n_flag;
   logic            taken;
   logic [PC_W-1:0] target;

   assign imem_addr = pc;
   assign pc_out    = pc;
   assign pc_plus1  = pc + PC_W'(1);
   assign opcode    = instr[INSTR_W-1 -: 4];
   assign busy      = (state != FETCH);

   // Registered flags give old-value semantics when flag_we coincides with resolve_valid.
   assign taken  = Jump | (branchZ & z_flag) | (branchN & n_flag);
   assign target = jumpMem ? mem_target : reg_target;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         z_flag      <= 1'b0;
         n_flag      <= 1'b0;
         instr       <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
`ifdef PERF_CNT_EN
         retired_cnt <= '0;
         taken_cnt   <= '0;
`endif
      end else begin
         if (flag_we) begin
            z_flag <= alu_z;
            n_flag <= alu_n;
         end
         case (state)
            // imem_req is raised on entry to FETCH; only the first FETCH after reset spends a cycle raising it.
            FETCH: begin
               if (imem_req) begin
                  imem_req <= 1'b0;
                  state    <= WAIT;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= RESOLVE;
               end
            end
            RESOLVE: begin
               if (resolve_valid) begin
                  pc       <= taken ? target : pc_plus1;
                  imem_req <= 1'b1;
                  state    <= FETCH;
`ifdef PERF_CNT_EN
                  retired_cnt <= retired_cnt + 32'd1;
                  if (taken) taken_cnt <= taken_cnt + 32'd1;
`endif
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-side counterpart of the opcode decoder: owns the PC, fetches instruction words from instruction memory and presents them with the opcode to the decoder.
- Consumes the decoder's redirect controls (branchN, branchZ, Jump, jumpMem) and ALU flags, then computes the next PC.
- Single-issue, unpipelined: one instruction in flight from fetch to resolution.

Parameters:
PC_W, 32, PC and address width
INSTR_W, 32, instruction word width; opcode = instr[INSTR_W-1 -: 4]
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
imem_req  out  1  one-cycle fetch request pulse
imem_addr  out  PC_W  fetch address (= pc)
imem_rvalid  in  1  instruction word valid
imem_rdata  in  INSTR_W  instruction word
instr_valid  out  1  instruction presented to decoder
instr_ready  in  1  decoder accepts instruction
instr  out  INSTR_W  held instruction word
opcode  out  4  instr top 4 bits
pc_out  out  PC_W  PC of presented instruction
pc_plus1  out  PC_W  pc+1, link value for PCtoReg writeback
resolve_valid  in  1  decoder/execute controls valid this cycle
branchN, branchZ, Jump, jumpMem  in  1 each  redirect controls
reg_target  in  PC_W  target from register operand
mem_target  in  PC_W  target read from data memory
flag_we  in  1  update flag registers
alu_z, alu_n  in  1 each  ALU zero / negative results
busy  out  1  high in every state except FETCH

Behaviour:
- Reset, asynchronous: pc=RESET_PC, state=FETCH, Z=N=0, instr=0, imem_req=0, instr_valid=0.
- States: FETCH, WAIT, ISSUE, RESOLVE.
- FETCH: drive imem_req=1 for exactly one cycle with imem_addr=pc, then go to WAIT.
- WAIT: on imem_rvalid, latch imem_rdata into instr and go to ISSUE. imem_rvalid is ignored in every other state.
- ISSUE: hold instr_valid=1 and keep instr stable until instr_ready. On the instr_valid & instr_ready cycle go to RESOLVE; instr_valid drops the next cycle.
- RESOLVE: wait for resolve_valid. On that cycle:
  - taken = Jump | (branchZ & Z) | (branchN & N)
  - target = jumpMem ? mem_target : reg_target
  - pc <= taken ? target : pc+1
  - state <= FETCH
- Fetch-to-fetch minimum is 4 cycles: FETCH, WAIT with rvalid, ISSUE with ready, RESOLVE with resolve_valid.
- Flags Z/N load from alu_z/alu_n on flag_we in any state.
  - If flag_we and resolve_valid occur in the same cycle, resolution uses the old registered flags; the new values are visible from the next cycle.
- pc arithmetic is modulo 2^PC_W: pc=all-ones, not taken -> next pc=0. pc_plus1 wraps the same way.
- Control inputs are ignored outside RESOLVE.
- Reset mid-operation: immediate return to reset values. The instruction memory must not return data for requests issued before reset.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: adds outputs retired_cnt[31:0] and taken_cnt[31:0], both cleared on rst.
  - retired_cnt increments on each resolve_valid in RESOLVE.
  - taken_cnt increments when taken=1 on that cycle.
  - Both wrap at 2^32.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then imem returns 0x4000_0000 one cycle after the request, instr_ready=1 immediately, resolve_valid with all controls 0 -> imem_addr sequence 0,1; opcode=4'b0100; 4 cycles between imem_req pulses.
- instr_ready held low for 5 cycles -> instr_valid stays 1 and instr stays stable for those 5 cycles; no new imem_req.
- flag_we with alu_z=1, then resolve with branchZ=1, reg_target=0x40 -> next imem_addr=0x40. Repeat with Z=0 -> pc+1.
- Same-cycle flag_we (alu_n=1) and resolve with branchN=1 while N=0 -> not taken. The next branchN resolve is taken.
- Jump=1, jumpMem=1, mem_target=0x80, reg_target=0x10 -> next imem_addr=0x80. pc=0xFFFF_FFFF not taken -> next addr 0.
- Assert rst in WAIT -> imem_req=0, instr_valid=0 asynchronously. After release, first imem_addr=RESET_PC. With PERF_CNT_EN defined, both counters read 0.
